// File: rtl/cipher_pkg.sv
// Shared types and constants for the byte-stream XOR cipher controller.
package cipher_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] KS_SEED      = 8'h01;
  localparam logic [7:0] TAP_MASK     = 8'hB8;
  localparam logic [7:0] ZERO_KEY_SUB = 8'h01;

  // Galois-free Fibonacci step: taps 7,5,4,3 fold into bit 0.
  function automatic logic [7:0] ks_next(input logic [7:0] ks);
    return {ks[6:0], ^(ks & TAP_MASK)};
  endfunction
endpackage

// File: rtl/cipher_stream_ctrl_if.sv
// Frame control plus byte-in / byte-out handshakes of the cipher controller.
interface cipher_stream_ctrl_if #(parameter int LEN_W = 8);
  logic             start;
  logic [7:0]       key;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (output start, key, frame_len, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, busy, done);
  modport slave  (input  start, key, frame_len, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, busy, done);
endinterface

// File: rtl/cipher_ks_step.sv
// Keystream register: load wins over step; holds otherwise.
module cipher_ks_step
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] ks
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ks <= KS_SEED;
    else if (load) ks <= seed;
    else if (en)   ks <= ks_next(ks);
  end
endmodule

// File: rtl/cipher_stream_ctrl.sv
// Frame controller: XORs each accepted byte with an LFSR keystream, one-deep output register.
module cipher_stream_ctrl
  import cipher_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  cipher_stream_ctrl_if.slave bus
);
  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       ks;
  logic [7:0]       seed;
  logic             out_valid_r;
  logic [7:0]       out_data_r;
  logic             in_ready_c;
  logic             accept, in_hs, out_hs;

  assign accept = (state == IDLE) && bus.start;
  assign in_hs  = bus.in_valid && in_ready_c;
  assign out_hs = out_valid_r && bus.out_ready;
  assign seed   = (bus.key == 8'h00) ? ZERO_KEY_SUB : bus.key;

  cipher_ks_step u_ks (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .seed (seed),
    .en   (in_hs),
    .ks   (ks)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // RUN holds until the last byte has also left the output register.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.frame_len != '0) ? RUN : DONE;
      RUN:     if (remaining == '0 && (!out_valid_r || bus.out_ready)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state == RUN) && (remaining != '0) && (!out_valid_r || bus.out_ready);
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      if (accept)     remaining <= bus.frame_len;
      else if (in_hs) remaining <= remaining - LEN_W'(1);
      if (in_hs) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.in_data ^ ks;
      end else if (out_hs) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Scoreboard bench: driver pushes expected ciphertext per frame, negedge monitor pops on output handshakes.
module tb_cipher_stream_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cipher_stream_ctrl_if #(.LEN_W(8)) bus ();
  cipher_stream_ctrl #(.LEN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [7:0] expq[$];
  logic [7:0] dq[$];
  logic [7:0] litq[$];
  bit rand_rdy = 0, rand_gap = 0, rdy_manual = 0, zero_win = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_cmp++; n_err++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference keystream: shift left, new LSB is parity of bits 7,5,4,3.
  function automatic logic [7:0] ref_step(input logic [7:0] k);
    int p = $countones(k & 8'hB8) % 2;
    return 8'((int'(k) * 2) % 256 + p);
  endfunction

  task automatic push_model(input logic [7:0] key);
    logic [7:0] k = (key == 8'h00) ? 8'h01 : key;
    foreach (dq[i]) begin
      expq.push_back(dq[i] ^ k);
      k = ref_step(k);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rdy_manual) bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready_low", bus.in_ready, 0);
        prev_stall = 1;
        prev_data  = bus.out_data;
      end else prev_stall = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) fail_bound("unexpected_output");
        else chk("out_data", bus.out_data, expq.pop_front());
      end
      if (zero_win) chk("zero_len_quiet", {bus.in_ready, bus.out_valid}, 0);
      if (bus.done) done_cnt++;
    end
  end

  task automatic feed(input int n, input bit disturb, input bit stall);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      bit hs = 0;
      if (rand_gap) begin
        bus.in_valid = 0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.in_valid = 1;
      bus.in_data  = dq[i];
      if (stall && i == 1) begin
        rdy_manual = 1; bus.out_ready = 0;
        repeat (5) tick();
        rdy_manual = 0; bus.out_ready = 1;
      end
      while (!hs && guard < 100) begin
        if (disturb) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.key = 8'($urandom);
          bus.frame_len = 8'($urandom);
        end
        @(negedge clk);
        hs = bus.in_ready;
        tick();
        guard++;
      end
      if (!hs) fail_bound("in_handshake");
    end
    bus.in_valid = 0;
    bus.start = 0;
  endtask

  task automatic run_frame(input logic [7:0] key, input bit disturb, input bit stall);
    int d0 = done_cnt;
    int len = dq.size();
    int n = 0;
    if (litq.size() != 0) begin
      foreach (litq[i]) expq.push_back(litq[i]);
      litq.delete();
    end else push_model(key);
    bus.start = 1; bus.key = key; bus.frame_len = 8'(len);
    tick();
    bus.start = 0;
    if (len == 0) begin
      zero_win = 1;
      @(negedge clk);
      chk("zero_len_done_next", bus.done, 1);
    end
    feed(len, disturb, stall);
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (done_cnt == d0) fail_bound("done_wait");
    repeat (2) tick();
    zero_win = 0;
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", bus.busy, 0);
    chk("drained", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.start = 0; bus.key = 0; bus.frame_len = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    tick(); reset = 0; tick();

    dq = '{8'h00, 8'h00, 8'h00}; litq = '{8'hA5, 8'h4A, 8'h95};
    run_frame(8'hA5, 0, 0);
    dq = '{8'hFF, 8'hFF}; litq = '{8'hFE, 8'hFD};
    run_frame(8'h00, 0, 0);
    dq.delete();
    run_frame(8'h5C, 0, 0);
    dq = '{8'h00, 8'h00, 8'h00}; litq = '{8'hA5, 8'h4A, 8'h95};
    run_frame(8'hA5, 0, 1);
    dq = '{8'h00, 8'h00, 8'h00}; litq = '{8'hA5, 8'h4A, 8'h95};
    run_frame(8'hA5, 1, 0);

    // abort mid-frame with the first ciphertext byte still held
    d0 = done_cnt;
    dq = '{8'h00, 8'h00, 8'h00}; push_model(8'hA5);
    bus.start = 1; bus.key = 8'hA5; bus.frame_len = 8'd3;
    tick(); bus.start = 0;
    feed(1, 0, 0);
    #3 reset = 1; #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    expq.delete();
    tick(); tick(); reset = 0;
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    dq = '{8'h00}; litq = '{8'h01};
    run_frame(8'h01, 0, 0);

    rand_rdy = 1; rand_gap = 1;
    for (int f = 0; f < 10; f++) begin
      int len = $urandom_range(0, 8);
      logic [7:0] k = (f == 3) ? 8'h00 : 8'($urandom);
      dq.delete();
      for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
      run_frame(k, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
